prog_run_ctrl: RTL and testbench
================================

# prog_run_ctrl

Run-control sequencer for the processor datapath. On a `go` request it copies a program of `prog_len` words from the instruction ROM into the datapath instruction memory, pulses the datapath start, then paces execution with a clock-enable instead of a divided clock. It handles free-run, single-step, datapath halt, resume and abort. It sits in `top` between `inst_ROM`, the resume button edge detector and `datapath`, all on the 100 MHz clock.

## Interface
- `ADDR_W`, 12, instruction address width.
- `INST_W`, 16, instruction word width.
- `CE_DIV`, 4, run-mode pacing: one `dp_ce` pulse every `CE_DIV` cycles (≥1).

Ports (clock and reset first):
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  single-cycle pulse: start load and run; honoured only in IDLE.
- `abort`  in  1  single-cycle pulse: return to IDLE from any state.
- `step_mode`  in  1  level: 1 = single-step, 0 = free-run.
- `resume`  in  1  single-cycle pulse, already debounced and edge-detected.
- `prog_len`  in  ADDR_W  number of words to load; 0 = load nothing.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_data`  in  INST_W  ROM data, valid one cycle after `rom_addr`.
- `inst_we`  out  1  datapath instruction memory write strobe.
- `inst_addr`  out  ADDR_W  write address.
- `inst_wdata`  out  INST_W  write data, combinational pass-through of `rom_data`.
- `dp_start`  out  1  one-cycle start pulse to datapath.
- `dp_ce`  out  1  datapath clock enable.
- `dp_halt`  in  1  level from datapath; rising edge requests halt.
- `busy`  out  1  high whenever state ≠ IDLE.
- `state`  out  3  current state encoding.

## Operation
- States and encodings: IDLE=0, LOAD=1, FLUSH=2, START=3, RUN=4, HALTED=5, STEP=6.
- IDLE → LOAD on `go`. `rom_addr` is loaded with 0. If `prog_len`=0, the transition is IDLE → START instead.
- LOAD:
  - `rom_addr` increments by one each cycle.
  - When `rom_addr` = `prog_len`−1, the next state is FLUSH.
  - `prog_len` is sampled at `go`; later changes are ignored.
- Write pipeline: `inst_we` and `inst_addr` are `rom_addr`-valid and `rom_addr` delayed one register stage.
- FLUSH: the final write completes; the next state is START.
- START: `dp_start`=1 for this cycle only. The next state is HALTED if `step_mode`=1, otherwise RUN.
- RUN:
  - The pace counter counts 0..`CE_DIV`−1 and wraps.
  - `dp_ce`=1 exactly when the counter = `CE_DIV`−1. With `CE_DIV`=1, `dp_ce` is high every RUN cycle.
- `dp_halt` handling:
  - A rising edge of `dp_halt` is detected against its registered previous value.
  - In RUN, an edge moves the state to HALTED next cycle, and `dp_ce` is forced 0 in the detection cycle.
  - In any other state, `dp_halt` edges are ignored.
- HALTED, on `resume`:
  - If `step_mode`=1, the next state is STEP.
  - If `step_mode`=0, the next state is RUN and the pace counter is cleared.
- STEP: `dp_ce`=1 for exactly this cycle, then the state returns to HALTED.
- Ignored inputs:
  - `resume` outside HALTED.
  - `go` outside IDLE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE.
  - `inst_we`, `dp_ce` and `dp_start` are 0 from the next cycle.
  - A partial load is not completed.
- Simultaneous events:
  - `abort` beats everything.
  - A halt edge beats everything else in RUN.

## Timing
- Reset (asynchronous) values:
  - state=IDLE, `rom_addr`=0, `inst_addr`=0, pace counter=0, halt history=0.
  - `inst_we`=0, `dp_start`=0, `dp_ce`=0, `busy`=0.
- `go` sampled at cycle 0, with `prog_len`=N>0:
  - LOAD during cycles 1..N, with `rom_addr`=k at cycle k+1.
  - `inst_we`=1 during cycles 2..N+1, with `inst_addr`=k at cycle k+2.
  - FLUSH at cycle N+1.
  - START, with `dp_start`=1, at cycle N+2.
  - RUN or HALTED from cycle N+3.
- `prog_len`=0: START at cycle 1, `dp_start`=1 at cycle 1, no writes.
- First `dp_ce` in RUN: the `CE_DIV`-th cycle after RUN entry (entry cycle counts as counter=0).
- Resume to STEP: `resume` at cycle t, `dp_ce`=1 at cycle t+1, HALTED at t+2.
- Halt: an edge arriving at cycle t gives `dp_ce`=0 at cycle t and HALTED at t+1.
- An asynchronous `rst` mid-load clears all outputs immediately. Instruction memory contents are undefined afterwards.

## Test plan
- Load: reset, `prog_len`=4, ROM word k = 0xA000+k, pulse `go` → writes (addr 0..3, data 0xA000..0xA003) on cycles 2..5, `dp_start` at cycle 6, RUN at cycle 7.
- Zero length: `prog_len`=0, `go` → no `inst_we`, `dp_start` at cycle 1.
- Pacing: `CE_DIV`=4, free-run → `dp_ce` at RUN cycles 3, 7, 11. Also run with `CE_DIV`=1 → `dp_ce` continuous.
- Halt and resume: raise `dp_halt` in RUN → no `dp_ce` that cycle, HALTED (5) next cycle. Pulse `resume` → RUN with counter cleared, next `dp_ce` `CE_DIV`−1 cycles later.
- Single-step: `step_mode`=1, three `resume` pulses → exactly three `dp_ce` pulses, each one cycle after its `resume`. A `resume` during STEP is ignored.
- Abort and reset: `abort` at LOAD cycle 2 of 8 → IDLE next cycle, no further writes, `busy`=0. Re-`go` reloads from address 0. `go` while RUN is ignored. Async `rst` mid-RUN zeroes all outputs without a clock edge.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// Run-control sequencer: copies prog_len ROM words into instruction memory, pulses dp_start, then paces the datapath via dp_ce.
// Write pipeline is one register behind rom_addr; there is no backpressure, and abort returns to IDLE from any state on the next edge.
module prog_run_ctrl #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 16,
    parameter int CE_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic              i_abort,
    input  logic              i_step_mode,
    input  logic              i_resume,
    input  logic [ADDR_W-1:0] i_prog_len,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [INST_W-1:0] i_rom_data,
    output logic              o_inst_we,
    output logic [ADDR_W-1:0] o_inst_addr,
    output logic [INST_W-1:0] o_inst_wdata,
    output logic              o_dp_start,
    output logic              o_dp_ce,
    input  logic              i_dp_halt,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] FLUSH  = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;
    localparam logic [2:0] STEP   = 3'd6;

    localparam int PACE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(CE_DIV - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_prog_len;
    logic              r_inst_we;
    logic [ADDR_W-1:0] r_inst_addr;
    logic [PACE_W-1:0] r_pace;
    logic              r_halt_q;
    logic              w_halt_edge;
    logic              w_load_last;
    logic              w_go_accept;

    assign w_halt_edge = i_dp_halt & ~r_halt_q;
    assign w_load_last = (r_rom_addr == (r_prog_len - ADDR_W'(1)));
    assign w_go_accept = (r_state == IDLE) && i_go && !i_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort dominates; a halt edge is the only thing that can leave RUN otherwise
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_go) w_next = (i_prog_len == '0) ? START : LOAD;
                LOAD:    if (w_load_last) w_next = FLUSH;
                FLUSH:   w_next = START;
                START:   w_next = i_step_mode ? HALTED : RUN;
                RUN:     if (w_halt_edge) w_next = HALTED;
                HALTED:  if (i_resume) w_next = i_step_mode ? STEP : RUN;
                STEP:    w_next = HALTED;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_dp_start = (r_state == START);
        o_dp_ce    = ((r_state == RUN) && (r_pace == PACE_LAST) && !w_halt_edge)
                   || (r_state == STEP);
        o_busy     = (r_state != IDLE);
        o_state    = r_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rom_addr  <= '0;
            r_prog_len  <= '0;
            r_inst_we   <= 1'b0;
            r_inst_addr <= '0;
            r_pace      <= '0;
            r_halt_q    <= 1'b0;
        end else begin
            if (w_go_accept) begin
                r_rom_addr <= '0;
                r_prog_len <= i_prog_len;
            end else if (r_state == LOAD) begin
                r_rom_addr <= r_rom_addr + ADDR_W'(1);
            end

            // ROM data lands one cycle after its address, so the write trails by one stage
            r_inst_we <= (r_state == LOAD) && !i_abort;
            if (r_state == LOAD) begin
                r_inst_addr <= r_rom_addr;
            end

            if ((r_state == RUN) && (w_next == RUN)) begin
                r_pace <= (r_pace == PACE_LAST) ? '0 : r_pace + PACE_W'(1);
            end else begin
                r_pace <= '0;
            end

            r_halt_q <= i_dp_halt;
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_inst_we    = r_inst_we;
    assign o_inst_addr  = r_inst_addr;
    assign o_inst_wdata = i_rom_data;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: load, pacing (CE_DIV 4 and 1), halt/resume, single-step, abort and async reset.
module tb_prog_run_ctrl;
    localparam int AW = 12;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, go, abort, step_mode, resume, dp_halt;
    logic [AW-1:0] prog_len;
    logic [IW-1:0] rom_data;

    logic [AW-1:0] a_rom_addr, a_inst_addr, b_rom_addr, b_inst_addr;
    logic [IW-1:0] a_inst_wdata, b_inst_wdata;
    logic          a_inst_we, a_dp_start, a_dp_ce, a_busy;
    logic          b_inst_we, b_dp_start, b_dp_ce, b_busy;
    logic [2:0]    a_state, b_state;

    int n_total = 0;
    int n_bad   = 0;

    prog_run_ctrl #(.ADDR_W(AW), .INST_W(IW), .CE_DIV(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_abort(abort),
        .i_step_mode(step_mode), .i_resume(resume), .i_prog_len(prog_len),
        .o_rom_addr(a_rom_addr), .i_rom_data(rom_data), .o_inst_we(a_inst_we),
        .o_inst_addr(a_inst_addr), .o_inst_wdata(a_inst_wdata),
        .o_dp_start(a_dp_start), .o_dp_ce(a_dp_ce), .i_dp_halt(dp_halt),
        .o_busy(a_busy), .o_state(a_state)
    );

    prog_run_ctrl #(.ADDR_W(AW), .INST_W(IW), .CE_DIV(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_abort(abort),
        .i_step_mode(step_mode), .i_resume(resume), .i_prog_len(prog_len),
        .o_rom_addr(b_rom_addr), .i_rom_data(rom_data), .o_inst_we(b_inst_we),
        .o_inst_addr(b_inst_addr), .o_inst_wdata(b_inst_wdata),
        .o_dp_start(b_dp_start), .o_dp_ce(b_dp_ce), .i_dp_halt(dp_halt),
        .o_busy(b_busy), .o_state(b_state)
    );

    // ROM word k = 0xA000 + k, one cycle read latency
    always @(posedge clk) rom_data <= 16'hA000 + 16'(a_rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_st;
        int n_ce;
        int k;
        logic we_e;

        rst = 1'b1; go = 1'b0; abort = 1'b0; step_mode = 1'b0;
        resume = 1'b0; dp_halt = 1'b0; prog_len = '0;
        #12;
        chk("rst_state", a_state, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_we", a_inst_we, 0);
        chk("rst_start", a_dp_start, 0);
        chk("rst_ce", a_dp_ce, 0);
        chk("rst_rom_addr", a_rom_addr, 0);
        chk("rst_inst_addr", a_inst_addr, 0);
        tick();
        rst = 1'b0;
        tick();

        // load 4 words; prog_len changes mid-load must be ignored
        go = 1'b1; prog_len = 12'd4;
        for (int c = 1; c <= 7; c++) begin
            tick();
            go = 1'b0;
            if (c == 1) prog_len = 12'd2;
            exp_st = (c <= 4) ? 1 : (c == 5) ? 2 : (c == 6) ? 3 : 4;
            chk($sformatf("load_state_c%0d", c), a_state, exp_st);
            chk($sformatf("load_busy_c%0d", c), a_busy, 1);
            if (c <= 4) chk($sformatf("load_rom_addr_c%0d", c), a_rom_addr, c - 1);
            we_e = (c >= 2 && c <= 5);
            chk($sformatf("load_we_c%0d", c), a_inst_we, we_e);
            if (we_e) begin
                chk($sformatf("load_addr_c%0d", c), a_inst_addr, c - 2);
                chk($sformatf("load_data_c%0d", c), a_inst_wdata, 16'hA000 + c - 2);
                chk($sformatf("load_data_b_c%0d", c), b_inst_wdata, 16'hA000 + c - 2);
            end
            chk($sformatf("load_start_c%0d", c), a_dp_start, (c == 6));
        end

        // free-run pacing from RUN entry
        for (int r = 0; r < 12; r++) begin
            chk($sformatf("run_state_r%0d", r), a_state, 4);
            chk($sformatf("run_state_b_r%0d", r), b_state, 4);
            chk($sformatf("pace4_r%0d", r), a_dp_ce, (r % 4 == 3));
            chk($sformatf("pace1_r%0d", r), b_dp_ce, 1);
            tick();
        end

        // go while RUN is ignored (RUN cycle 13 afterwards)
        go = 1'b1; prog_len = 12'd4;
        tick();
        go = 1'b0;
        chk("go_in_run_state", a_state, 4);
        chk("go_in_run_rom_addr", a_rom_addr, 4);
        chk("go_in_run_ce", a_dp_ce, 0);
        tick(); tick();

        // halt edge on a cycle that would otherwise fire dp_ce
        dp_halt = 1'b1;
        #1;
        chk("halt_ce_forced", a_dp_ce, 0);
        chk("halt_ce_forced_b", b_dp_ce, 0);
        chk("halt_detect_state", a_state, 4);
        tick();
        chk("halted_state", a_state, 5);
        chk("halted_ce", a_dp_ce, 0);
        tick();
        chk("halted_hold", a_state, 5);

        resume = 1'b1;
        tick();
        resume = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("resume_state_r%0d", r), a_state, 4);
            chk($sformatf("resume_ce_r%0d", r), a_dp_ce, (r == 3));
            tick();
        end
        dp_halt = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_in_run_ignored", a_state, 4);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_state", a_state, 0);
        chk("abort_run_busy", a_busy, 0);
        chk("abort_run_ce", a_dp_ce, 0);

        // zero-length program straight into single-step
        step_mode = 1'b1; prog_len = '0; go = 1'b1;
        tick();
        go = 1'b0;
        chk("zero_state", a_state, 3);
        chk("zero_start", a_dp_start, 1);
        chk("zero_we_c1", a_inst_we, 0);
        tick();
        chk("zero_halted", a_state, 5);
        chk("zero_start_off", a_dp_start, 0);
        chk("zero_we_c2", a_inst_we, 0);

        n_ce = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("step_wait_%0d", i), a_state, 5);
            n_ce += int'(a_dp_ce);
            resume = 1'b1;
            tick();
            resume = 1'b0;
            chk($sformatf("step_state_%0d", i), a_state, 6);
            chk($sformatf("step_ce_%0d", i), a_dp_ce, 1);
            n_ce += int'(a_dp_ce);
            if (i == 0) resume = 1'b1;
            tick();
            resume = 1'b0;
            chk($sformatf("step_back_%0d", i), a_state, 5);
            n_ce += int'(a_dp_ce);
        end
        tick();
        n_ce += int'(a_dp_ce);
        chk("step_ce_count", n_ce, 3);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_halted_state", a_state, 0);

        // abort at LOAD cycle 2 of an 8-word load
        step_mode = 1'b0; prog_len = 12'd8; go = 1'b1;
        tick();
        go = 1'b0;
        chk("l8_state_c1", a_state, 1);
        tick();
        chk("l8_we_c2", a_inst_we, 1);
        chk("l8_addr_c2", a_inst_addr, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("l8_abort_state", a_state, 0);
        chk("l8_abort_busy", a_busy, 0);
        chk("l8_abort_we", a_inst_we, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("l8_idle_we_%0d", i), a_inst_we, 0);
            chk($sformatf("l8_idle_state_%0d", i), a_state, 0);
        end

        go = 1'b1;
        tick();
        go = 1'b0;
        chk("reload_state", a_state, 1);
        chk("reload_rom_addr", a_rom_addr, 0);
        tick();
        chk("reload_we", a_inst_we, 1);
        chk("reload_addr", a_inst_addr, 0);
        chk("reload_data", a_inst_wdata, 16'hA000);

        k = 0;
        while (a_state != 3'd4 && k < 20) begin
            tick();
            k++;
        end
        chk("reload_reach_run", a_state, 4);
        k = 0;
        while (!a_dp_ce && k < 8) begin
            tick();
            k++;
        end
        chk("reload_ce_seen", a_dp_ce, 1);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", a_state, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_ce", a_dp_ce, 0);
        chk("arst_start", a_dp_start, 0);
        chk("arst_we", a_inst_we, 0);
        chk("arst_inst_addr", a_inst_addr, 0);
        chk("arst_rom_addr", a_rom_addr, 0);
        chk("arst_b_ce", b_dp_ce, 0);
        chk("arst_b_state", b_state, 0);
        chk("arst_b_misc", {b_busy, b_dp_start, b_inst_we}, 0);
        chk("arst_b_addr", {b_inst_addr, b_rom_addr}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_state", a_state, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
